// File: rtl/bigmul_pkg.sv
// bigmul_pkg: constants and state encoding shared by the big-integer multiplier and its drain stage
package bigmul_pkg;
    localparam int NDIAGS     = 128;
    localparam int NWORDS     = 64;
    localparam int LIMB_W     = 64;
    localparam int LIMB_BYTES = 8;
    typedef enum logic [1:0] {IDLE, CHECK, STREAM, FINISH} state_e;
endpackage

// File: rtl/bigmul_skid_fifo.sv
// bigmul_skid_fifo: DEPTH x W synchronous FIFO, head visible the cycle after a push (no fall-through)
module bigmul_skid_fifo #(
    parameter  int DEPTH = 2,
    parameter  int W     = 64,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == CW'(DEPTH);
    assign count   = cnt_q;
    assign rdata   = mem_q[rptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Write the pushed word, advance wrapping pointers, track occupancy
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wptr_q] = wdata;
        wptr_d = do_push ? (wptr_q == PW'(DEPTH - 1) ? '0 : wptr_q + PW'(1)) : wptr_q;
        rptr_d = do_pop ? (rptr_q == PW'(DEPTH - 1) ? '0 : rptr_q + PW'(1)) : rptr_q;
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage needs no reset: the head is only consumed while count is nonzero
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Pointer and occupancy registers, emptied on reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/bigmul_result_drain.sv
// bigmul_result_drain: streams result-cache limbs, LSB limb first, to memory over a valid/ready write channel
module bigmul_result_drain
    import bigmul_pkg::*;
#(
    parameter int NDIAGS = bigmul_pkg::NDIAGS,
    parameter int AW     = 64,
    parameter int DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      start,
    input  logic [31:0]               operand_size,
    input  logic [AW-1:0]             base_addr,
    output logic                      rc_rd_en,
    output logic [$clog2(NDIAGS)-1:0] rc_rd_addr,
    input  logic [LIMB_W-1:0]         rc_rd_data,
    output logic                      mem_wvalid,
    input  logic                      mem_wready,
    output logic [AW-1:0]             mem_waddr,
    output logic [LIMB_W-1:0]         mem_wdata,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int CW = $clog2(NDIAGS + 1);
    localparam int FW = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [31:0]       size_q, size_d;
    logic [AW-1:0]     base_q, base_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, n;
    logic              inflight_q, inflight_d, err_q, err_d;
    logic              illegal, pop, fifo_empty, fifo_full;
    logic [FW-1:0]     fifo_count;
    logic [LIMB_W-1:0] fifo_rdata;

    assign n       = CW'({size_q, 1'b0});
    assign illegal = size_q == '0 || size_q > 32'(NDIAGS / 2);
    assign pop     = mem_wvalid && mem_wready;

    // A write leaving this cycle frees its slot, so the cache read stream keeps pace with an always-ready sink
    assign rc_rd_en   = state_q == STREAM && rd_cnt_q < n && (!fifo_full || pop) &&
                        (fifo_count + FW'(inflight_q) - FW'(pop)) < FW'(DEPTH);
    assign rc_rd_addr = rc_rd_en ? rd_cnt_q[$clog2(NDIAGS)-1:0] : '0;
    assign mem_wvalid = !fifo_empty;
    assign mem_wdata  = mem_wvalid ? fifo_rdata : '0;
    assign mem_waddr  = mem_wvalid ? base_q + AW'(wr_cnt_q) * AW'(LIMB_BYTES) : '0;
    assign busy       = state_q == CHECK || state_q == STREAM;
    assign done       = state_q == FINISH;
    assign err        = done && err_q;

    bigmul_skid_fifo #(.DEPTH(DEPTH), .W(LIMB_W)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (inflight_q),
        .pop   (pop),
        .wdata (rc_rd_data),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Next-state: latch request, validate size, count reads and accepted writes, then pulse done
    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        base_d     = base_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        err_d      = err_q;
        inflight_d = rc_rd_en;
        case (state_q)
            IDLE: if (start) begin
                state_d = CHECK;
                size_d  = operand_size;
                base_d  = base_addr;
                err_d   = 1'b0;
            end
            CHECK: begin
                state_d  = illegal ? FINISH : STREAM;
                err_d    = illegal;
                rd_cnt_d = '0;
                wr_cnt_d = '0;
            end
            STREAM: begin
                rd_cnt_d = rd_cnt_q + CW'(rc_rd_en);
                wr_cnt_d = wr_cnt_q + CW'(pop);
                if (wr_cnt_q == n) state_d = FINISH;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any read in flight
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            size_q     <= '0;
            base_q     <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            base_q     <= base_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end
endmodule
